// File: rtl/cv_cart_bridge.sv
// cv_cart_bridge: Z80 cart-space reads to SDRAM with MegaCart banking and a one-entry byte cache
module cv_cart_bridge #(
    parameter int ADDR_W  = 20,
    parameter int TIMEOUT = 63
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              sg1000_i,
    input  logic [5:0]        cart_pages_i,
    input  logic [15:0]       cpu_a_i,
    input  logic              cpu_mreq_n_i,
    input  logic              cpu_rd_n_i,
    output logic [7:0]        cpu_d_o,
    output logic              cpu_wait_n_o,
    output logic              cart_sel_o,
    output logic [ADDR_W-1:0] sdram_addr_o,
    output logic              sdram_rd_o,
    input  logic              sdram_ready_i,
    input  logic [7:0]        sdram_d_i
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN, S_HOLD} state_e;

    state_e            state_q;
    logic [5:0]        bank_q, bank_d;
    logic              armed_q;
    logic [6:0]        cfg_q;
    logic              c_valid_q;
    logic [ADDR_W-1:0] c_addr_q;
    logic [7:0]        c_data_q;
    logic [CW-1:0]     cnt_q;
    logic [7:0]        d_q;
    logic              wait_n_q, rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              megacart, accept, bank_chg, cfg_chg, hit, timeout;
    logic [ADDR_W-1:0] map_addr;

    assign cart_sel_o   = (sg1000_i ? (cpu_a_i[15:14] != 2'b11) : cpu_a_i[15]) & ~cpu_mreq_n_i & ~cpu_rd_n_i;
    assign megacart     = ~sg1000_i & (cart_pages_i > 6'd1);
    // Bank register is written from the top 64 bytes; the new bank is used by this very read
    assign bank_d       = (megacart && cpu_a_i[15:6] == 10'h3FF) ? (cpu_a_i[5:0] & cart_pages_i) : bank_q;
    assign map_addr     = sg1000_i  ? ADDR_W'(cpu_a_i) :
                          !megacart ? ADDR_W'(cpu_a_i[14:0]) :
                                      ADDR_W'({cpu_a_i[14] ? bank_d : cart_pages_i, cpu_a_i[13:0]});
    // armed_q guarantees one request per bus cycle, so a reset or drain never reissues a read
    assign accept       = (state_q == S_IDLE) & cart_sel_o & armed_q;
    assign bank_chg     = accept & (bank_d != bank_q);
    assign cfg_chg      = {sg1000_i, cart_pages_i} != cfg_q;
    assign hit          = c_valid_q & ~bank_chg & (c_addr_q == map_addr);
    assign timeout      = cnt_q == CW'(TIMEOUT - 1);
    assign cpu_d_o      = d_q;
    assign cpu_wait_n_o = wait_n_q;
    assign sdram_rd_o   = rd_q;
    assign sdram_addr_o = addr_q;

    // Bus-cycle FSM with registered CPU/SDRAM outputs, bank register and cache entry
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_IDLE;
            bank_q    <= '0;
            armed_q   <= 1'b0;
            cfg_q     <= '0;
            c_valid_q <= 1'b0;
            c_addr_q  <= '0;
            c_data_q  <= '0;
            cnt_q     <= '0;
            d_q       <= 8'hFF;
            wait_n_q  <= 1'b1;
            rd_q      <= 1'b0;
            addr_q    <= '0;
        end else begin
            cfg_q   <= {sg1000_i, cart_pages_i};
            armed_q <= ~cart_sel_o | (armed_q & ~accept);
            rd_q    <= 1'b0;
            cnt_q   <= (state_q == S_WAIT || state_q == S_DRAIN) ? cnt_q + CW'(1) : '0;
            if (cfg_chg || bank_chg) c_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: if (accept) begin
                    bank_q <= bank_d;
                    if (hit) begin
                        d_q     <= c_data_q;
                        state_q <= S_HOLD;
                    end else begin
                        addr_q   <= map_addr;
                        rd_q     <= 1'b1;
                        wait_n_q <= 1'b0;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: if (sdram_ready_i) begin
                    d_q      <= sdram_d_i;
                    wait_n_q <= 1'b1;
                    state_q  <= S_HOLD;
                    if (!cfg_chg) begin
                        c_valid_q <= 1'b1;
                        c_addr_q  <= addr_q;
                        c_data_q  <= sdram_d_i;
                    end
                end else if (!cart_sel_o) begin
                    wait_n_q <= 1'b1;
                    state_q  <= S_DRAIN;
                end else if (timeout) begin
                    d_q      <= 8'hFF;
                    wait_n_q <= 1'b1;
                    state_q  <= S_HOLD;
                end
                S_DRAIN: if (sdram_ready_i || timeout) state_q <= S_IDLE;
                S_HOLD:  if (!cart_sel_o) state_q <= S_IDLE;
            endcase
        end
    end
endmodule
